alu_cmd_sequencer: RTL

- Initiator-side companion to the team's ALU.
- Accepts operation commands on a valid/ready stream.
- Drives the ALU's execute/oper/A/B inputs for one cycle, then captures the registered result.
- Returns the result on a valid/ready response stream with backpressure.
- Sits between the command memory/testbench agent and the ALU, owning all ALU handshake timing.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_cmd_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, sequencer states,
// the ALU's divide-by-zero result code and the error-decode helper.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_CLR = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } seq_state_e;

    // Result the ALU returns for a division by zero.
    localparam logic [15:0] ALU_ERROR_CODE = 16'hDEAD;

    // An operation is in error when the opcode is outside the defined set
    // or when it is a division by zero.
    function automatic logic op_is_error(input logic [2:0] oper, input logic b_is_zero);
        return (oper > OP_DIV) || ((oper == OP_DIV) && b_is_zero);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side sequencer for the team's ALU. Takes one command from a
// valid/ready stream, strobes the ALU for one cycle, captures the
// registered result and returns it on a valid/ready response stream.
// Optional: define ALU_SEQ_ERR_EN to add the rsp_err output.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    // command stream
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_oper,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    // ALU interface
    output logic                    alu_execute,
    output logic [2:0]              alu_oper,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    input  logic [2*DATA_WIDTH-1:0] alu_res,
    // response stream
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
`ifdef ALU_SEQ_ERR_EN
    output logic                    rsp_err,
`endif
    output logic [CNT_WIDTH-1:0]    ops_done
);

    seq_state_e                state_q, state_d;
    logic [2:0]                oper_q, oper_d;
    logic [DATA_WIDTH-1:0]     a_q, a_d;
    logic [DATA_WIDTH-1:0]     b_q, b_d;
    logic [2*DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_WIDTH-1:0]      ops_done_q, ops_done_d;
`ifdef ALU_SEQ_ERR_EN
    logic                      err_q, err_d;
`endif

    // Handshake outputs decode straight from the state. cmd_ready is also
    // gated by reset_n so nothing is accepted while reset is held.
    assign cmd_ready   = reset_n && (state_q == IDLE);
    assign alu_execute = (state_q == EXEC);
    assign rsp_valid   = (state_q == RESP);

    assign alu_oper = oper_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign rsp_data = rsp_data_q;
    assign ops_done = ops_done_q;
`ifdef ALU_SEQ_ERR_EN
    assign rsp_err  = err_q;
`endif

    // Next-state and datapath update for the four-phase command sequence.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the
        // case statement can leave it unassigned and infer a latch.
        state_d    = state_q;
        oper_d     = oper_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        ops_done_d = ops_done_q;
`ifdef ALU_SEQ_ERR_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    oper_d  = cmd_oper;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = CAPT;
            end
            CAPT: begin
                // The ALU result is registered, so it is valid one cycle
                // after the execute strobe.
                rsp_data_d = alu_res;
`ifdef ALU_SEQ_ERR_EN
                err_d      = op_is_error(oper_q, (b_q == '0));
`endif
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + CNT_WIDTH'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            oper_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            ops_done_q <= '0;
`ifdef ALU_SEQ_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q    <= state_d;
            oper_q     <= oper_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            ops_done_q <= ops_done_d;
`ifdef ALU_SEQ_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule
